// File: rtl/sdram_model_pkg.sv
// sdram_model_pkg: command codes, error bit indices and mode-word decode for the SDRAM chip model.
package sdram_model_pkg;
   typedef enum logic [2:0] {
      CMD_LMR  = 3'b000,
      CMD_AREF = 3'b001,
      CMD_PRE  = 3'b010,
      CMD_ACT  = 3'b011,
      CMD_WR   = 3'b100,
      CMD_RD   = 3'b101,
      CMD_BST  = 3'b110,
      CMD_NOP  = 3'b111
   } cmd_t;
   localparam int ERR_IDLE = 0;
   localparam int ERR_ACT  = 1;
   localparam int ERR_TIM  = 2;
   localparam int ERR_MODE = 3;
   localparam logic [2:0] CL_MIN = 3'd2;
   localparam logic [2:0] CL_MAX = 3'd3;
   function automatic logic bl_legal(input logic [2:0] code);
      return code <= 3'd3 || code == 3'd7;
   endfunction
   // Column wrap mask (burst length - 1); illegal codes fall back to a single word.
   function automatic logic [7:0] bl_mask_of(input logic [2:0] code);
      return code == 3'd7 ? 8'hFF : code <= 3'd3 ? 8'((1 << code) - 1) : 8'h00;
   endfunction
endpackage

// File: rtl/sdram_model_ram.sv
// sdram_model_ram: simple dual-port x16 RAM with byte enables and 1-cycle synchronous read.
module sdram_model_ram #(
   parameter int AW = 14
) (
   input  logic          clk,
   input  logic          we,
   input  logic [1:0]    be,
   input  logic [AW-1:0] waddr,
   input  logic [15:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [15:0]   rdata
);
   logic [15:0] mem [2**AW];
   always_ff @(posedge clk) begin
      if (we && be[0]) mem[waddr][7:0] <= wdata[7:0];
      if (we && be[1]) mem[waddr][15:8] <= wdata[15:8];
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/sdram_chip_model.sv
// sdram_chip_model: x16 4-bank SDRAM responder backed by block RAM, with protocol checking.
// Define SDRAM_MODEL_TIMING_EN to enable TRCD/TRP/TRFC checking on err[2].
module sdram_chip_model
   import sdram_model_pkg::*;
#(
   parameter int MEM_AW = 14,
   parameter int TRCD   = 2,
   parameter int TRP    = 2,
   parameter int TRFC   = 7
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sdram_cke,
   input  logic        sdram_cs_n,
   input  logic        sdram_ras_n,
   input  logic        sdram_cas_n,
   input  logic        sdram_we_n,
   input  logic [1:0]  sdram_ba,
   input  logic [12:0] sdram_addr,
   input  logic [1:0]  sdram_dqm,
   input  logic [15:0] dq_in,
   output logic [15:0] dq_out,
   output logic        dq_oe,
   output logic        init_done,
   output logic [12:0] mode_reg,
   output logic [15:0] ref_cnt,
   output logic [3:0]  err
);
   cmd_t cmd;
   logic cl3, single_wr, bst_act, bst_wr, bst_ap, ap_pend, v0, v1, tim_err;
   logic is_rw, issue, issue_wr, issue_ap, issue_last, cl_ok, rd_vld;
   logic [1:0] bst_ba, ap_ba, i_ba;
   logic [3:0] bank_open, err_set;
   logic [7:0] bl_mask, bst_col, bst_rem, bst_mask, i_col, i_mask, i_rem, nxt_col;
   logic [12:0] bank_row [4];
   logic [12:0] bst_row, i_row;
   logic [15:0] rdata, d1;
   logic [MEM_AW-1:0] mem_addr;
   assign cmd = (sdram_cke && !sdram_cs_n) ? cmd_t'({sdram_ras_n, sdram_cas_n, sdram_we_n}) : CMD_NOP;
   assign is_rw = cmd == CMD_WR || cmd == CMD_RD;
   // A new READ/WRITE preempts the running burst; BURST STOP suppresses this cycle's word.
   assign issue = is_rw || (bst_act && cmd != CMD_BST);
   assign issue_wr = is_rw ? cmd == CMD_WR : bst_wr;
   assign i_ba = is_rw ? sdram_ba : bst_ba;
   assign i_row = is_rw ? (bank_open[sdram_ba] ? bank_row[sdram_ba] : '0) : bst_row;
   assign i_col = is_rw ? sdram_addr[7:0] : bst_col;
   assign i_mask = is_rw ? bl_mask : bst_mask;
   assign i_rem = is_rw ? (cmd == CMD_WR && single_wr ? 8'd0 : bl_mask) : bst_rem;
   assign issue_ap = is_rw ? sdram_addr[10] && i_rem != 8'hFF : bst_ap;
   assign issue_last = issue && i_rem == 8'd0;
   assign nxt_col = (i_col & ~i_mask) | ((i_col + 8'd1) & i_mask);
   assign mem_addr = MEM_AW'({i_ba, i_row, i_col});
   assign cl_ok = sdram_addr[6:4] == CL_MIN || sdram_addr[6:4] == CL_MAX;
   assign rd_vld = cl3 ? v1 : v0;
   always_comb begin
      err_set = '0;
      err_set[ERR_IDLE] = is_rw && !bank_open[sdram_ba];
      err_set[ERR_ACT] = cmd == CMD_ACT && bank_open[sdram_ba];
      err_set[ERR_TIM] = tim_err;
      err_set[ERR_MODE] = (cmd == CMD_LMR && (!cl_ok || !bl_legal(sdram_addr[2:0])))
                        || (!init_done && (is_rw || cmd == CMD_ACT || cmd == CMD_BST));
   end
   sdram_model_ram #(.AW(MEM_AW)) u_ram (
      .clk(clk), .we(issue && issue_wr), .be(~sdram_dqm), .waddr(mem_addr),
      .wdata(dq_in), .raddr(mem_addr), .rdata(rdata)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         dq_out <= '0;
         dq_oe <= 1'b0;
         init_done <= 1'b0;
         mode_reg <= '0;
         ref_cnt <= '0;
         err <= '0;
         cl3 <= 1'b1;
         bl_mask <= '0;
         single_wr <= 1'b0;
         bank_open <= '0;
         bank_row <= '{default: '0};
         bst_act <= 1'b0;
         bst_wr <= 1'b0;
         bst_ap <= 1'b0;
         bst_ba <= '0;
         bst_row <= '0;
         bst_col <= '0;
         bst_rem <= '0;
         bst_mask <= '0;
         ap_pend <= 1'b0;
         ap_ba <= '0;
         v0 <= 1'b0;
         v1 <= 1'b0;
         d1 <= '0;
      end else begin
         // RAM output is one stage; CL 3 adds a second register stage before dq_out.
         v0 <= issue && !issue_wr;
         v1 <= v0;
         d1 <= rdata;
         dq_oe <= rd_vld;
         dq_out <= rd_vld ? (cl3 ? d1 : rdata) : '0;
         err <= err | err_set;
         if (issue) begin
            bst_act <= i_rem != 8'd0;
            bst_wr <= issue_wr;
            bst_ap <= issue_ap;
            bst_ba <= i_ba;
            bst_row <= i_row;
            bst_col <= nxt_col;
            bst_rem <= i_rem - 8'd1;
            bst_mask <= i_mask;
         end else if (cmd == CMD_BST) bst_act <= 1'b0;
         ap_pend <= issue_last && issue_ap;
         ap_ba <= i_ba;
         if (ap_pend) bank_open[ap_ba] <= 1'b0;
         if (cmd == CMD_LMR) begin
            mode_reg <= sdram_addr;
            init_done <= 1'b1;
            cl3 <= sdram_addr[6:4] != CL_MIN;
            bl_mask <= bl_mask_of(sdram_addr[2:0]);
            single_wr <= sdram_addr[9];
         end
         if (cmd == CMD_AREF) ref_cnt <= ref_cnt + 16'd1;
         if (cmd == CMD_ACT) begin
            bank_open[sdram_ba] <= 1'b1;
            bank_row[sdram_ba] <= sdram_addr;
         end
         if (cmd == CMD_PRE) begin
            if (sdram_addr[10]) bank_open <= '0;
            else bank_open[sdram_ba] <= 1'b0;
         end
      end
`ifdef SDRAM_MODEL_TIMING_EN
   logic [7:0] rcd [4];
   logic [7:0] rp [4];
   logic [7:0] rfc;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rcd <= '{default: '0};
         rp <= '{default: '0};
         rfc <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            rcd[i] <= (cmd == CMD_ACT && sdram_ba == 2'(i)) ? 8'(TRCD - 1) : (rcd[i] != 0 ? rcd[i] - 8'd1 : 8'd0);
            rp[i] <= (cmd == CMD_PRE && (sdram_addr[10] || sdram_ba == 2'(i))) ? 8'(TRP - 1) : (rp[i] != 0 ? rp[i] - 8'd1 : 8'd0);
         end
         rfc <= cmd == CMD_AREF ? 8'(TRFC - 1) : (rfc != 0 ? rfc - 8'd1 : 8'd0);
      end
   assign tim_err = (is_rw && rcd[sdram_ba] != 0) || (cmd == CMD_ACT && rp[sdram_ba] != 0)
                  || (cmd != CMD_NOP && rfc != 0);
`else
   logic [31:0] unused_tim;
   assign unused_tim = TRCD ^ TRP ^ TRFC;
   assign tim_err = 1'b0;
`endif
endmodule

// File: tb/tb_sdram_chip_model.sv
// tb_sdram_chip_model: directed scoreboard bench for sdram_chip_model.
module tb_sdram_chip_model;
   logic clk = 1'b0, rst_n = 1'b0;
   logic cke = 1'b1, cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
   logic [1:0] ba = 2'd0, dqm = 2'd0;
   logic [12:0] addr = 13'd0;
   logic [15:0] dq_in = 16'd0;
   logic [15:0] dq_out, ref_cnt;
   logic dq_oe, init_done;
   logic [12:0] mode_reg;
   logic [3:0] err;
   int cyc = 0, checks = 0, errors = 0, n_edge = 0, cl = 3;
   string nm_q[$];
   logic [31:0] act_q[$];
   logic [31:0] req_q[$];
   int at_q[$];
   logic [15:0] dat_q[$];
   localparam logic [2:0] LMR = 3'b000, AREF = 3'b001, PRE = 3'b010, ACT = 3'b011;
   localparam logic [2:0] WR = 3'b100, RD = 3'b101, BST = 3'b110;
`ifdef SDRAM_MODEL_TIMING_EN
   localparam logic [3:0] TIM = 4'b0100;
`else
   localparam logic [3:0] TIM = 4'b0000;
`endif

   sdram_chip_model dut (
      .clk(clk), .rst_n(rst_n), .sdram_cke(cke), .sdram_cs_n(cs_n), .sdram_ras_n(ras_n),
      .sdram_cas_n(cas_n), .sdram_we_n(we_n), .sdram_ba(ba), .sdram_addr(addr), .sdram_dqm(dqm),
      .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe), .init_done(init_done), .mode_reg(mode_reg),
      .ref_cnt(ref_cnt), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: drains snapshot checks, then matches every read word against its scheduled cycle.
   always @(negedge clk) begin : monitor
      string nm;
      logic [31:0] a, r;
      int at;
      logic [15:0] d;
      while (nm_q.size() > 0) begin
         nm = nm_q.pop_front();
         a = act_q.pop_front();
         r = req_q.pop_front();
         checks++;
         if (a !== r) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, a, r);
         end
      end
      if (rst_n && dq_oe) begin
         checks++;
         if (at_q.size() == 0) begin
            errors++;
            $display("FAIL rd_extra: cycle %0d got %h, expected no word", cyc, dq_out);
         end else begin
            at = at_q.pop_front();
            d = dat_q.pop_front();
            if (at != cyc || dq_out !== d) begin
               errors++;
               $display("FAIL rd_word: cycle %0d got %h, expected %h at cycle %0d", cyc, dq_out, d, at);
            end
         end
      end else if (at_q.size() > 0 && at_q[0] < cyc) begin
         checks++;
         errors++;
         d = dat_q.pop_front();
         $display("FAIL rd_missing: no word at cycle %0d, expected %h", at_q.pop_front(), d);
      end
   end

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] r);
      nm_q.push_back(nm);
      act_q.push_back(a);
      req_q.push_back(r);
   endtask

   task automatic cmd(input logic [2:0] c, input logic [1:0] b = 2'd0, input logic [12:0] a = 13'd0,
                      input logic [15:0] d = 16'hDEAD, input logic [1:0] m = 2'd0);
      @(negedge clk);
      {ras_n, cas_n, we_n} = c;
      cs_n = 1'b0;
      ba = b;
      addr = a;
      dq_in = d;
      dqm = m;
      n_edge = cyc + 1;
   endtask

   task automatic idle(input int n, input logic [15:0] d = 16'hDEAD);
      repeat (n) begin
         @(negedge clk);
         {cs_n, ras_n, cas_n, we_n} = 4'b1111;
         dq_in = d;
         dqm = 2'd0;
      end
   endtask

   task automatic exp_word(input int k, input logic [15:0] d);
      at_q.push_back(n_edge + cl - 1 + k);
      dat_q.push_back(d);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dq_out", 32'(dq_out), 32'h0);
      chk("rst_dq_oe", 32'(dq_oe), 32'h0);
      chk("rst_init_done", 32'(init_done), 32'h0);
      chk("rst_mode_reg", 32'(mode_reg), 32'h0);
      chk("rst_ref_cnt", 32'(ref_cnt), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cmd(AREF);
      idle(8);
      chk("ref_cnt", 32'(ref_cnt), 32'h1);
      // CL3 BL8 burst writes fill columns 0x10..0x17 of bank 1 row 5
      cmd(LMR, 2'd0, 13'h0033);
      idle(1);
      chk("mode_reg_33", 32'(mode_reg), 32'h033);
      chk("init_done", 32'(init_done), 32'h1);
      cmd(ACT, 2'd1, 13'h0005);
      idle(1);
      cmd(WR, 2'd1, 13'h0010, 16'h1000);
      for (int k = 1; k < 8; k++) idle(1, 16'h1000 + 16'(k));
      // single-location write mode: only column 0x10 changes
      cmd(LMR, 2'd0, 13'h0233);
      idle(1);
      cmd(WR, 2'd1, 13'h0010, 16'hA5A5);
      idle(8, 16'hDEAD);
      cmd(RD, 2'd1, 13'h0010);
      exp_word(0, 16'hA5A5);
      for (int k = 1; k < 8; k++) exp_word(k, 16'h1000 + 16'(k));
      idle(12);
      chk("err_clean", 32'(err), 32'h0);
      // CL2 BL8 wrap inside the aligned block
      cmd(LMR, 2'd0, 13'h0023);
      cl = 2;
      idle(1);
      cmd(WR, 2'd1, 13'h000E, 16'h2000);
      for (int k = 1; k < 8; k++) idle(1, 16'h2000 + 16'(k));
      cmd(RD, 2'd1, 13'h000E);
      for (int k = 0; k < 8; k++) exp_word(k, 16'h2000 + 16'(k));
      idle(12);
      cmd(RD, 2'd1, 13'h0008);
      for (int k = 0; k < 3; k++) exp_word(k, 16'h2000 + 16'((k + 2) % 8));
      idle(2);
      cmd(RD, 2'd1, 13'h000E);
      for (int k = 0; k < 8; k++) exp_word(k, 16'h2000 + 16'(k));
      idle(12);
      // full page, CL3, burst stop
      cmd(LMR, 2'd0, 13'h0037);
      cl = 3;
      idle(1);
      cmd(WR, 2'd1, 13'h00FE, 16'h3000);
      for (int k = 1; k < 6; k++) idle(1, 16'h3000 + 16'(k));
      cmd(BST, 2'd0, 13'h0000, 16'hBAD0);
      idle(2);
      cmd(RD, 2'd1, 13'h00FE);
      for (int k = 0; k < 5; k++) exp_word(k, 16'h3000 + 16'(k));
      idle(4);
      cmd(BST);
      idle(3);
      chk("bst_oe_low", 32'(dq_oe), 32'h0);
      idle(3);
      // BL1, byte mask, then auto-precharge closes bank 2
      cmd(LMR, 2'd0, 13'h0030);
      idle(1);
      cmd(ACT, 2'd2, 13'h0001);
      idle(1);
      cmd(WR, 2'd2, 13'h0020, 16'hFFFF, 2'b00);
      cmd(WR, 2'd2, 13'h0020, 16'h1234, 2'b10);
      idle(1);
      cmd(RD, 2'd2, 13'h0420);
      exp_word(0, 16'hFF34);
      idle(2);
      cmd(ACT, 2'd2, 13'h0001);
      idle(6);
      chk("err_after_ap", 32'(err), 32'h0);
      // read to an idle bank uses row 0
      cmd(ACT, 2'd0, 13'h0000);
      idle(1);
      cmd(WR, 2'd0, 13'h0040, 16'h4444);
      cmd(PRE, 2'd0, 13'h0000);
      idle(2);
      cmd(RD, 2'd0, 13'h0040);
      exp_word(0, 16'h4444);
      idle(6);
      chk("err_idle", 32'(err), 32'h1);
      // READ one cycle after ACTIVE
      cmd(ACT, 2'd3, 13'h0007);
      idle(1);
      cmd(WR, 2'd3, 13'h0050, 16'h5555);
      cmd(PRE, 2'd0, 13'h0400);
      idle(2);
      cmd(ACT, 2'd3, 13'h0007);
      cmd(RD, 2'd3, 13'h0050);
      exp_word(0, 16'h5555);
      idle(6);
      chk("err_trcd", 32'(err), 32'(4'b0001 | TIM));
      // ACTIVE to open bank, illegal mode word falls back to CL3 BL1
      cmd(ACT, 2'd3, 13'h0007);
      idle(1);
      cmd(LMR, 2'd0, 13'h0045);
      idle(2);
      chk("mode_reg_45", 32'(mode_reg), 32'h045);
      chk("err_act_mode", 32'(err), 32'(4'b1011 | TIM));
      cmd(RD, 2'd3, 13'h0050);
      exp_word(0, 16'h5555);
      idle(6);
      // reset in the middle of a full-page read
      cmd(LMR, 2'd0, 13'h0037);
      idle(1);
      cmd(ACT, 2'd1, 13'h0005);
      idle(1);
      cmd(RD, 2'd1, 13'h00FE);
      for (int k = 0; k < 6; k++) exp_word(k, 16'h3000 + 16'(k));
      idle(3);
      @(posedge clk);
      #1;
      chk("mid_burst_oe", 32'(dq_oe), 32'h1);
      #1;
      rst_n = 1'b0;
      at_q.delete();
      dat_q.delete();
      #1;
      chk("rstb_dq_oe", 32'(dq_oe), 32'h0);
      chk("rstb_dq_out", 32'(dq_out), 32'h0);
      chk("rstb_err", 32'(err), 32'h0);
      chk("rstb_init_done", 32'(init_done), 32'h0);
      chk("rstb_mode_reg", 32'(mode_reg), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(4);
      chk("post_rst_oe", 32'(dq_oe), 32'h0);
      chk("post_rst_init", 32'(init_done), 32'h0);
      chk("rd_pending", 32'(at_q.size()), 32'h0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
